// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the cacheline arbiter: FSM states, requester ids and the default line width.
package arb_pkg;

  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } arb_req_t;

endpackage

// File: rtl/cacheline_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical-memory line handshakes seen by the arbiter.
interface cacheline_arbiter_if
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_W_DEF
);

  // Handshake: a requester holds read/write (a level) plus address/data until the
  // one-cycle resp pulse; rdata is valid only while resp is high. The pmem side uses
  // the same rule: the command stays up until pmem_resp, and a command is never aborted.
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  // The arbiter side.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  // The caches plus memory, seen as one environment.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cacheline_arbiter_pick.sv
// Grant decision for the arbiter. ARB_ROUND_ROBIN_EN selects alternation on contention;
// otherwise the D-cache always wins.
module arb_pick
  import arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_req_t last_grant,
  output arb_req_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = REQ_I;
    if (i_req && d_req) begin
      grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (d_req) begin
      grant = REQ_D;
    end
  end
`else
  // last_grant is tracked by the caller but plays no part in fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = REQ_I;
    if (d_req) begin
      grant = REQ_D;
    end else if (i_req) begin
      grant = REQ_I;
    end
  end
`endif

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one 256-bit memory port between I-cache and D-cache, one transaction at a time.
// Contention policy is chosen by ARB_ROUND_ROBIN_EN (see arb_pick).
module cacheline_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_W_DEF
)(
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  bus,
  output arb_state_t          state,
  output arb_req_t            last_grant
);

  arb_state_t        state_next;
  arb_req_t          last_next;
  arb_req_t          grant;
  logic              i_req;
  logic              d_req;

  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [LINE_W-1:0] cmd_wdata;
  logic              resp_i;
  logic              resp_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_I;
    end else begin
      state      <= state_next;
      last_grant <= last_next;
    end
  end

  // Commands follow the granted requester's live inputs, so a dropped request is
  // visible to memory; the grant itself is only released by pmem_resp.
  always_comb begin
    state_next  = state;
    last_next   = last_grant;
    cmd_read    = 1'b0;
    cmd_write   = 1'b0;
    cmd_address = '0;
    cmd_wdata   = '0;
    resp_i      = 1'b0;
    resp_d      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          state_next = (grant == REQ_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        cmd_read    = bus.i_read;
        cmd_address = bus.i_address;
        resp_i      = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_next = IDLE;
          last_next  = REQ_I;
        end
      end
      SERVE_D: begin
        cmd_write   = bus.d_write;
        cmd_read    = bus.d_read & ~bus.d_write;
        cmd_address = bus.d_address;
        cmd_wdata   = bus.d_wdata;
        resp_d      = bus.pmem_resp;
        if (bus.pmem_resp) begin
          state_next = IDLE;
          last_next  = REQ_D;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pmem_read    = cmd_read;
  assign bus.pmem_write   = cmd_write;
  assign bus.pmem_address = cmd_address;
  assign bus.pmem_wdata   = cmd_wdata;
  assign bus.i_resp       = resp_i;
  assign bus.d_resp       = resp_d;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule
